// File: rtl/t05_pkg.sv
// Shared stage encodings, packer state type and pad helper for the t05 byte packer.
package t05_pkg;

   localparam logic [3:0] ST_ENCODE    = 4'd5;
   localparam logic [3:0] ST_EOF       = 4'd6;
   localparam logic [3:0] ST_PACK_DONE = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PACK,
      S_PAD,
      S_DRAIN,
      S_DONE
   } packer_state_t;

   // Moves the cnt payload bits held in the low end of sh up to bit 7, fills the rest with pad.
   function automatic logic [7:0] pad_byte(input logic [7:0] sh, input logic [2:0] cnt,
                                           input logic pad);
      logic [7:0] r;
      r = sh << (4'd8 - {1'b0, cnt});
      for (int unsigned i = 0; i < 8; i++) begin
         if (i + 32'(cnt) < 32'd8) r[i] = pad;
      end
      return r;
   endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// Synchronous FIFO; a push while full is only taken when a pop frees the slot in the same cycle.
module t05_byte_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/t05_byte_packer.sv
// Packs the translation bit stream MSB-first into bytes, pads the tail on flush,
// drains the output FIFO and signals completion to the top-level FSM.
module t05_byte_packer
   import t05_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic        PAD_BIT    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  en_state,
   input  logic        writeBin,
   input  logic        writeEn,
   input  logic        flush,
   input  logic        byte_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic [31:0] bit_count,
   output logic        overflow,
   output logic [3:0]  fin_state
);

   packer_state_t state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   bits_q, bits_d;
   logic          overflow_q, overflow_d;

   logic          push, pop, accept;
   logic [7:0]    push_data;
   logic          fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   t05_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (byte_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign byte_valid = !fifo_empty;
   assign pop        = byte_valid && byte_ready;
   assign accept     = writeEn && (en_state == ST_ENCODE) &&
                       ((state_q == S_IDLE) || (state_q == S_PACK));

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      bits_d    = bits_q;
      push      = 1'b0;
      push_data = '0;
      fin_state = '0;

      if (accept) begin
         sh_d   = {sh_q[6:0], writeBin};
         cnt_d  = cnt_q + 3'd1;
         bits_d = bits_q + 32'd1;
         if (cnt_q == 3'd7) begin
            push      = 1'b1;
            push_data = {sh_q[6:0], writeBin};
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (flush)                        state_d = S_PAD;
            else if (en_state == ST_ENCODE)   state_d = S_PACK;
         end
         S_PACK: begin
            if (flush) state_d = S_PAD;
         end
         S_PAD: begin
            if (cnt_q == 3'd0) begin
               sh_d    = '0;
               state_d = S_DRAIN;
            end else if (!fifo_full || pop) begin
               push      = 1'b1;
               push_data = pad_byte(sh_q, cnt_q, PAD_BIT);
               sh_d      = '0;
               cnt_d     = '0;
               state_d   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // count reaches zero only after the final pop edge, so DONE follows it
            if (fifo_count == '0) state_d = S_DONE;
         end
         S_DONE: begin
            fin_state = ST_PACK_DONE;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      overflow_d = overflow_q | (push && fifo_full && !pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sh_q       <= '0;
         cnt_q      <= '0;
         bits_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         bits_q     <= bits_d;
         overflow_q <= overflow_d;
      end
   end

   assign bit_count = bits_q;
   assign overflow  = overflow_q;

endmodule
